// File: rtl/run_ctrl_pkg.sv
// run_ctrl shared types: run-state encoding and command opcodes.
// Imported by run_ctrl and run_ctrl_counter.
package run_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RESETTING = 2'd0,
    ST_HALTED    = 2'd1,
    ST_RUNNING   = 2'd2,
    ST_STEPPING  = 2'd3
  } run_state_e;

  localparam logic [1:0] CMD_RUN     = 2'd0;
  localparam logic [1:0] CMD_HALT    = 2'd1;
  localparam logic [1:0] CMD_STEP    = 2'd2;
  localparam logic [1:0] CMD_RESTART = 2'd3;

  function automatic logic is_active(run_state_e s);
    return (s == ST_RUNNING) || (s == ST_STEPPING);
  endfunction

endpackage

// File: rtl/run_ctrl_counter.sv
// Wrapping W-bit counter: async reset, sync clear (wins), enable.
// Ports: clk, reset, i_en, i_clr, o_count[W-1:0].
module run_ctrl_counter
  import run_ctrl_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_en,
  input  logic         i_clr,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/run_ctrl.sv
// Run/halt controller for the Tenyr core: sequences core reset/halt
// from run/halt/step/restart commands, optional PC breakpoint stop,
// cycle and retired-instruction counters.
// Ports: clk, reset (async, active-high), cmd_valid/cmd_op/cmd_ready,
//   retire, pc, bp_valid, bp_addr, core_reset, halt, run_state,
//   bp_hit, cycle_count, insn_count.
// Macro RUN_CTRL_BREAKPOINT_EN enables the breakpoint compare;
// when undefined bp_valid/bp_addr/pc are ignored and bp_hit is 0.
module run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int RESET_CYCLES = 3,
  parameter int AUTORUN      = 1,
  parameter int CNT_W        = 32,
  parameter int ADDR_W       = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  input  logic [1:0]        cmd_op,
  output logic              cmd_ready,
  input  logic              retire,
  input  logic [ADDR_W-1:0] pc,
  input  logic              bp_valid,
  input  logic [ADDR_W-1:0] bp_addr,
  output logic              core_reset,
  output logic              halt,
  output logic [1:0]        run_state,
  output logic              bp_hit,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [CNT_W-1:0]  insn_count
);

  localparam int RCW =
    (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [RCW-1:0] RC_LAST = RCW'(RESET_CYCLES - 1);

  run_state_e     r_state;
  run_state_e     w_next;
  logic [RCW-1:0] r_rst_cnt;
  logic [RCW-1:0] w_rst_cnt_nxt;
  logic           r_autorun;
  logic           w_autorun_nxt;
  logic           r_core_reset;
  logic           r_halt;
  logic           r_cmd_ready;
  logic           r_bp_hit;
  logic           w_bp_hit_nxt;
  logic           w_acc;
  logic           w_bp_match;
  logic           w_clr;

  assign w_acc = cmd_valid && r_cmd_ready;

`ifdef RUN_CTRL_BREAKPOINT_EN
  assign w_bp_match = retire && bp_valid && (pc == bp_addr);
`else
  logic w_unused_bp;
  assign w_unused_bp = ^{bp_valid, bp_addr, pc};
  assign w_bp_match  = 1'b0;
`endif

  always_comb begin
    w_next        = r_state;
    w_rst_cnt_nxt = '0;
    w_autorun_nxt = 1'b0;
    w_bp_hit_nxt  = 1'b0;
    unique case (r_state)
      ST_RESETTING: begin
        if (r_rst_cnt == RC_LAST) begin
          w_next        = ST_HALTED;
          w_autorun_nxt = (AUTORUN != 0);
        end else begin
          w_rst_cnt_nxt = r_rst_cnt + RCW'(1);
        end
      end
      ST_HALTED: begin
        // a command in the autorun cycle overrides the auto start
        if (w_acc) begin
          unique case (cmd_op)
            CMD_RUN:     w_next = ST_RUNNING;
            CMD_STEP:    w_next = ST_STEPPING;
            CMD_RESTART: w_next = ST_RESETTING;
            default:     w_next = ST_HALTED;
          endcase
        end else if (r_autorun) begin
          w_next = ST_RUNNING;
        end
      end
      ST_RUNNING: begin
        if (w_acc && cmd_op == CMD_RESTART) begin
          w_next = ST_RESETTING;
        end else if (w_acc && cmd_op == CMD_HALT) begin
          w_next = ST_HALTED;
        end else if (w_bp_match) begin
          w_next       = ST_HALTED;
          w_bp_hit_nxt = 1'b1;
        end
      end
      ST_STEPPING: begin
        if (w_acc && cmd_op == CMD_RESTART) begin
          w_next = ST_RESETTING;
        end else if (w_acc && cmd_op == CMD_HALT) begin
          w_next = ST_HALTED;
        end else if (retire) begin
          w_next       = ST_HALTED;
          w_bp_hit_nxt = w_bp_match;
        end else if (w_acc && cmd_op == CMD_RUN) begin
          w_next = ST_RUNNING;
        end
      end
      default: w_next = ST_RESETTING;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_RESETTING;
      r_rst_cnt    <= '0;
      r_autorun    <= 1'b0;
      r_core_reset <= 1'b1;
      r_halt       <= 1'b1;
      r_cmd_ready  <= 1'b0;
      r_bp_hit     <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_rst_cnt    <= w_rst_cnt_nxt;
      r_autorun    <= w_autorun_nxt;
      r_core_reset <= (w_next == ST_RESETTING);
      r_halt       <= !is_active(w_next);
      r_cmd_ready  <= (w_next != ST_RESETTING);
      r_bp_hit     <= w_bp_hit_nxt;
    end
  end

  // counters restart from zero whenever a reset sequence begins
  assign w_clr = (w_next == ST_RESETTING) &&
                 (r_state != ST_RESETTING);

  run_ctrl_counter #(.W(CNT_W)) u_cyc_cnt (
    .clk     (clk),
    .reset   (reset),
    .i_en    (!r_halt && !r_core_reset),
    .i_clr   (w_clr),
    .o_count (cycle_count)
  );

  run_ctrl_counter #(.W(CNT_W)) u_insn_cnt (
    .clk     (clk),
    .reset   (reset),
    .i_en    (retire && !r_core_reset),
    .i_clr   (w_clr),
    .o_count (insn_count)
  );

  assign core_reset = r_core_reset;
  assign halt       = r_halt;
  assign cmd_ready  = r_cmd_ready;
  assign bp_hit     = r_bp_hit;
  assign run_state  = r_state;

endmodule

// File: tb/tb_run_ctrl.sv
// Scoreboard bench for run_ctrl: random commands/retires against a
// behavioural model, including async reset pulses and counter wrap.
module tb_run_ctrl;

  localparam int RC  = 3;
  localparam int AR  = 1;
  localparam int CW  = 4;
  localparam int AW  = 32;
  localparam int MOD = 1 << CW;
`ifdef RUN_CTRL_BREAKPOINT_EN
  localparam bit BP_EN = 1'b1;
`else
  localparam bit BP_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          cmd_valid = 1'b0;
  logic [1:0]    cmd_op = 2'd0;
  logic          retire = 1'b0;
  logic [AW-1:0] pc = '0;
  logic          bp_valid = 1'b0;
  logic [AW-1:0] bp_addr = '0;
  logic          cmd_ready;
  logic          core_reset;
  logic          halt;
  logic [1:0]    run_state;
  logic          bp_hit;
  logic [CW-1:0] cycle_count;
  logic [CW-1:0] insn_count;

  run_ctrl #(
    .RESET_CYCLES (RC),
    .AUTORUN      (AR),
    .CNT_W        (CW),
    .ADDR_W       (AW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_op      (cmd_op),
    .cmd_ready   (cmd_ready),
    .retire      (retire),
    .pc          (pc),
    .bp_valid    (bp_valid),
    .bp_addr     (bp_addr),
    .core_reset  (core_reset),
    .halt        (halt),
    .run_state   (run_state),
    .bp_hit      (bp_hit),
    .cycle_count (cycle_count),
    .insn_count  (insn_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit cr;
    bit hl;
    bit rdy;
    bit bp;
    int st;
    int cyc;
    int ins;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  bit   mon_en = 1'b0;

  // model: 0 resetting, 1 halted, 2 running, 3 stepping
  int m_st, m_rc, m_cyc, m_ins;
  bit m_auto, m_bp;

  function automatic void m_reset();
    m_st = 0; m_rc = 0; m_cyc = 0; m_ins = 0;
    m_auto = 1'b0; m_bp = 1'b0;
  endfunction

  function automatic exp_t m_snap();
    exp_t e;
    e.cr  = (m_st == 0);
    e.hl  = !(m_st == 2 || m_st == 3);
    e.rdy = (m_st != 0);
    e.bp  = m_bp;
    e.st  = m_st;
    e.cyc = m_cyc;
    e.ins = m_ins;
    return e;
  endfunction

  function automatic void m_step(bit cv, int op, bit rt,
                                 logic [AW-1:0] p, bit bv,
                                 logic [AW-1:0] ba);
    bit acc = cv && (m_st != 0);
    bit hit = BP_EN && rt && bv && (p == ba);
    bit cr  = (m_st == 0);
    bit hl  = !(m_st == 2 || m_st == 3);
    int nx  = m_st;
    bit sb  = 1'b0;
    if (!cr && !hl) m_cyc = (m_cyc + 1) % MOD;
    if (!cr && rt)  m_ins = (m_ins + 1) % MOD;
    if (m_st == 0) begin
      m_rc++;
      if (m_rc == RC) begin nx = 1; m_rc = 0; end
    end else if (acc && op == 3) nx = 0;
    else if (acc && op == 1) nx = 1;
    else if (m_st == 2 && hit) begin nx = 1; sb = 1'b1; end
    else if (m_st == 3 && rt) begin nx = 1; sb = hit; end
    else if (acc && op == 0) nx = 2;
    else if (acc && op == 2) nx = (m_st == 1) ? 3 : m_st;
    else if (m_st == 1 && m_auto) nx = 2;
    m_auto = (m_st == 0 && nx == 1) ? (AR != 0) : 1'b0;
    if (nx == 0 && m_st != 0) begin
      m_cyc = 0; m_ins = 0; m_rc = 0;
    end
    m_st = nx;
    m_bp = sb;
  endfunction

  task automatic chk(string n, logic [31:0] got, logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d t=%0t", n, got, want, $time);
    end
  endtask

  initial begin
    exp_t e;
    wait (mon_en);
    forever begin
      @(posedge clk or posedge reset);
      #1;
      if (mon_en) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL queue_underflow got=empty want=entry");
        end else begin
          e = q.pop_front();
          chk("core_reset", 32'(core_reset), 32'(e.cr));
          chk("halt", 32'(halt), 32'(e.hl));
          chk("cmd_ready", 32'(cmd_ready), 32'(e.rdy));
          chk("bp_hit", 32'(bp_hit), 32'(e.bp));
          chk("run_state", 32'(run_state), 32'(e.st));
          chk("cycle_count", 32'(cycle_count), 32'(e.cyc));
          chk("insn_count", 32'(insn_count), 32'(e.ins));
        end
      end
    end
  end

  task automatic rst_pulse();
    m_reset();
    q.push_back(m_snap());
    reset = 1'b1;
    #3;
    reset = 1'b0;
  endtask

  task automatic drive(bit idle);
    int r;
    int op;
    cmd_valid = idle ? 1'b0 : ($urandom_range(0, 5) == 0);
    r  = $urandom_range(0, 19);
    op = (r < 7) ? 0 : (r < 11) ? 1 : (r < 18) ? 2 : 3;
    cmd_op = 2'(op);
    retire = 1'($urandom_range(0, 1));
    case ($urandom_range(0, 3))
      0:       pc = 32'h0FC;
      1:       pc = 32'h100;
      2:       pc = 32'h104;
      default: pc = $urandom;
    endcase
    bp_valid = ($urandom_range(0, 3) != 0);
    bp_addr  = 32'h100;
    m_step(cmd_valid, op, retire, pc, bp_valid, bp_addr);
    q.push_back(m_snap());
  endtask

  initial begin
    m_reset();
    #7;
    mon_en = 1'b1;
    @(negedge clk);
    rst_pulse();
    drive(1'b1);
    repeat (29) begin
      @(negedge clk);
      drive(1'b1);
    end
    repeat (3000) begin
      @(negedge clk);
      if ($urandom_range(0, 299) == 0) rst_pulse();
      drive(1'b0);
    end
    @(negedge clk);
    mon_en = 1'b0;
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/run_ctrl.md
# run_ctrl

Run/halt controller for the Tenyr core. Sequences the core's `reset` and `halt` inputs from a small command interface (run, halt, single-step, restart), enforces a minimum reset pulse, and stops the core on an optional PC breakpoint. Counts active clock cycles and retired instructions for software and bench inspection. Sits between the top level and the `Tenyr` instance, replacing hard-wired reset/halt timing.

## Interface

Parameters:
- `RESET_CYCLES`, 3: cycles `core_reset` is held after power-on reset or RESTART; legal range ≥1.
- `AUTORUN`, 1: 1 = enter RUNNING automatically after the reset sequence; 0 = stay HALTED.
- `CNT_W`, 32: width of both counters.
- `ADDR_W`, 32: width of `pc` and `bp_addr`.

Ports:
- `clk`  in  1  sole clock.
- `reset`  in  1  asynchronous, active-high.
- `cmd_valid`  in  1  command present.
- `cmd_op`  in  2  0 RUN, 1 HALT, 2 STEP, 3 RESTART.
- `cmd_ready`  out  1  command accepted when `cmd_valid && cmd_ready`.
- `retire`  in  1  core completed an instruction this cycle.
- `pc`  in  ADDR_W  address of the retiring instruction; qualified by `retire`.
- `bp_valid`  in  1  breakpoint armed.
- `bp_addr`  in  ADDR_W  breakpoint address.
- `core_reset`  out  1  to core `reset`.
- `halt`  out  1  to core `halt`.
- `run_state`  out  2  current state encoding.
- `bp_hit`  out  1  one-cycle pulse when a breakpoint stops the core.
- `cycle_count`  out  CNT_W  active cycles.
- `insn_count`  out  CNT_W  retired instructions.

## Operation

- States: RESETTING (0), HALTED (1), RUNNING (2), STEPPING (3). All outputs are registered.
- Async reset: state RESETTING, `core_reset`=1, `halt`=1, `cmd_ready`=0, `bp_hit`=0, both counts 0, internal reset counter 0.
- RESETTING:
  - `core_reset`=1, `halt`=1, `cmd_ready`=0; commands are ignored, not queued.
  - After RESET_CYCLES cycles in this state, go to HALTED.
- HALTED: `halt`=1, `core_reset`=0.
  - RUN → RUNNING. STEP → STEPPING. HALT → no-op. RESTART → RESETTING.
  - With AUTORUN=1, exactly one HALTED cycle follows each reset sequence, then RUNNING without a command. A command accepted in that cycle takes precedence.
- RUNNING: `halt`=0.
  - HALT → HALTED. RESTART → RESETTING. RUN and STEP are no-ops.
  - A breakpoint match → HALTED.
- STEPPING: `halt`=0.
  - First `retire` → HALTED.
  - HALT → HALTED. RESTART → RESETTING. RUN converts the step to RUNNING.
- Breakpoint match: `retire && bp_valid && pc == bp_addr` in RUNNING or STEPPING.
  - `bp_hit` pulses in the cycle the state becomes HALTED.
  - The breakpointed instruction has retired and is counted.
- `cycle_count`: +1 each cycle where registered `halt`=0 and `core_reset`=0.
- `insn_count`: +1 on each `retire` while `core_reset`=0, including retirements in HALTED (drain of an in-flight instruction).
- Both counters wrap modulo 2^CNT_W and are cleared to 0 on entry to RESETTING.
- Priority in one cycle: RESTART > HALT > breakpoint/step completion > RUN/STEP. `retire` is always counted, even when a command changes state in the same cycle.

## Timing

- `cmd_ready`=1 in HALTED, RUNNING and STEPPING; 0 in RESETTING.
- Command accepted at edge N: new `run_state`, `halt` and `core_reset` are visible after edge N (one-cycle latency).
- Power-on with RESET_CYCLES=3, AUTORUN=1: `core_reset` falls after edge 3, `halt` falls after edge 4. The two release points are one cycle apart and independent.
- Breakpoint or step stop: `retire` sampled at edge N; `halt`=1 and `bp_hit`=1 after edge N; `bp_hit` returns to 0 after edge N+1.
- Async `reset` mid-operation clears all state immediately. A RESTART command behaves identically except that it is synchronous.

## Configuration

- `RUN_CTRL_BREAKPOINT_EN`:
  - Defined: `bp_valid`/`bp_addr` compare logic is present, and breakpoint stops and `bp_hit` behave as above.
  - Undefined: ports remain for uniform instantiation but are ignored. `bp_hit` is tied 0, and only commands and step completion halt the core.

## Structure

- Package `run_ctrl_pkg`:
  - state enum (RESETTING/HALTED/RUNNING/STEPPING) and `cmd_op` constants (CMD_RUN, CMD_HALT, CMD_STEP, CMD_RESTART).
- Sub-module `run_ctrl_counter`:
  - CNT_W wrapping counter with enable and synchronous clear, async reset.
  - Instantiated twice (cycles, instructions).

## Test plan

- Power-on, RESET_CYCLES=3, AUTORUN=1, no commands → `core_reset` 1 for 3 cycles, `halt` releases 1 cycle later, `run_state`=2; `cycle_count`=10 after 10 running cycles.
- AUTORUN=0; STEP; `retire` 2 cycles later → state 1, `insn_count`=1, `halt` high the cycle after the retire.
- RUNNING, `bp_valid`=1, `bp_addr`=0x100, retires at 0xFC then 0x100 → `bp_hit` single pulse, HALTED, `insn_count`=2; with macro undefined, stays RUNNING.
- RUNNING with `retire` and HALT in the same cycle → HALTED, retirement counted; RESTART and HALT priority: RESTART wins, counts cleared.
- CNT_W=4, run 17 active cycles → `cycle_count` wraps to 1.
- Async `reset` pulse while STEPPING → immediate RESETTING, counts 0, `cmd_ready`=0 for RESET_CYCLES cycles, commands ignored.
